// File: rtl/verdict_pkg.sv
// rtl/verdict_pkg.sv - shared widths, record layout and pack/unpack helpers
package verdict_pkg;

  localparam int NUM_OUT = 4;
  localparam int DATA_W  = 64;
  localparam int TS_W    = 32;

  // Record layout: ts in the MSBs, activation mask, then lane data in the LSBs
  localparam int DATA_LSB = 0;
  localparam int AKTV_LSB = DATA_LSB + NUM_OUT * DATA_W;
  localparam int TS_LSB   = AKTV_LSB + NUM_OUT;
  localparam int REC_W    = TS_LSB + TS_W;

  typedef struct packed {
    logic [TS_W-1:0]           ts;
    logic [NUM_OUT-1:0]        aktv;
    logic [NUM_OUT*DATA_W-1:0] data;
  } rec_t;

  function automatic logic [REC_W-1:0] pack_rec(input logic [TS_W-1:0]           ts,
                                                 input logic [NUM_OUT-1:0]        aktv,
                                                 input logic [NUM_OUT*DATA_W-1:0] data);
    logic [REC_W-1:0] r;
    r = '0;
    r[TS_LSB +: TS_W]              = ts;
    r[AKTV_LSB +: NUM_OUT]         = aktv;
    r[DATA_LSB +: NUM_OUT*DATA_W]  = data;
    return r;
  endfunction

  function automatic rec_t unpack_rec(input logic [REC_W-1:0] r);
    rec_t x;
    x.ts   = r[TS_LSB +: TS_W];
    x.aktv = r[AKTV_LSB +: NUM_OUT];
    x.data = r[DATA_LSB +: NUM_OUT*DATA_W];
    return x;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with level count and full-with-pop push
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  // Full/empty come from the level so pointers can wrap freely modulo DEPTH
  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign dout    = mem[rd_ptr];

  // Storage write; the head is read combinationally so a fresh entry shows one edge later
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/verdict_collector.sv
// rtl/verdict_collector.sv - captures active monitor verdicts into a drained record stream
module verdict_collector
  import verdict_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int OVF_W = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic [NUM_OUT*DATA_W-1:0]   out_data,
  input  logic [NUM_OUT-1:0]          out_aktv,
  output logic                        rec_valid,
  input  logic                        rec_ready,
  output logic [TS_W-1:0]             rec_ts,
  output logic [NUM_OUT-1:0]          rec_aktv,
  output logic [NUM_OUT*DATA_W-1:0]   rec_data,
  output logic [$clog2(DEPTH):0]      level,
  output logic                        overflow,
  output logic [OVF_W-1:0]            drop_cnt
);

  logic [TS_W-1:0]           ts_cnt;
  logic [NUM_OUT*DATA_W-1:0] masked;
  logic                      capture;
  logic                      pop;
  logic                      full;
  logic                      empty;
  logic                      accept;
  logic                      drop;
  logic [REC_W-1:0]          head_raw;
  rec_t                      head;

  assign capture   = en && (|out_aktv);
  assign rec_valid = !empty;
  assign pop       = rec_valid && rec_ready;
  assign accept    = capture && (!full || pop);
  assign drop      = capture && !accept;
  assign head      = unpack_rec(head_raw);

  // Outputs read as zero whenever nothing is buffered, hiding stale storage
  assign rec_ts   = rec_valid ? head.ts   : '0;
  assign rec_aktv = rec_valid ? head.aktv : '0;
  assign rec_data = rec_valid ? head.data : '0;

  // Zero the lanes whose activation flag is clear
  always_comb begin
    masked = '0;
    for (int i = 0; i < NUM_OUT; i++) begin
      if (out_aktv[i]) begin
        masked[i*DATA_W +: DATA_W] = out_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Free-running cycle timestamp, advancing only while the monitor is enabled
  always_ff @(posedge clk) begin
    if (rst) begin
      ts_cnt <= '0;
    end else if (en) begin
      ts_cnt <= ts_cnt + TS_W'(1);
    end
  end

  // Sticky overflow flag and saturating count of records lost to a full buffer
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_cnt != '1) begin
        drop_cnt <= drop_cnt + OVF_W'(1);
      end
    end
  end

  sync_fifo #(
    .WIDTH (REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (accept),
    .pop   (pop),
    .din   (pack_rec(ts_cnt, out_aktv, masked)),
    .dout  (head_raw),
    .full  (full),
    .empty (empty),
    .level (level)
  );

endmodule

// File: tb/tb_verdict_collector.sv
// tb/tb_verdict_collector.sv - scoreboard bench for the verdict record path
module tb_verdict_collector;
  import verdict_pkg::*;

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      en;
  logic [NUM_OUT*DATA_W-1:0] out_data;
  logic [NUM_OUT-1:0]        out_aktv;
  logic                      rec_valid;
  logic                      rec_ready;
  logic [TS_W-1:0]           rec_ts;
  logic [NUM_OUT-1:0]        rec_aktv;
  logic [NUM_OUT*DATA_W-1:0] rec_data;
  logic [4:0]                level;
  logic                      overflow;
  logic [15:0]               drop_cnt;

  typedef struct {
    logic [31:0]  ts;
    logic [3:0]   aktv;
    logic [255:0] data;
  } exp_t;

  exp_t        expq[$];
  int          total = 0;
  int          bad = 0;
  logic [31:0] tsm;
  logic [31:0] ts_saved;

  verdict_collector #(.DEPTH(16), .OVF_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .out_data  (out_data),
    .out_aktv  (out_aktv),
    .rec_valid (rec_valid),
    .rec_ready (rec_ready),
    .rec_ts    (rec_ts),
    .rec_aktv  (rec_aktv),
    .rec_data  (rec_data),
    .level     (level),
    .overflow  (overflow),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [255:0] lanes(input logic [63:0] l0, input logic [63:0] l1,
                                         input logic [63:0] l2, input logic [63:0] l3);
    return {l3, l2, l1, l0};
  endfunction

  // Monitor: a handshake seen mid-cycle completes on the next edge, so compare the head now
  always @(negedge clk) begin
    exp_t e;
    if (rst === 1'b0 && rec_valid === 1'b1 && rec_ready === 1'b1) begin
      if (expq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_record actual_ts=%0h required=none", rec_ts);
      end else begin
        e = expq.pop_front();
        check("rec_ts", 256'(rec_ts), 256'(e.ts));
        check("rec_aktv", 256'(rec_aktv), 256'(e.aktv));
        check("rec_data", rec_data, e.data);
      end
    end
  end

  // One clock; the bench's timestamp model follows the same en/rst rule
  task automatic step();
    @(posedge clk);
    if (rst) tsm = '0;
    else if (en) tsm = tsm + 32'd1;
    #1;
  endtask

  task automatic ev(input logic [3:0] a, input logic [255:0] d, input logic [255:0] ed, input bit push);
    exp_t e;
    out_aktv = a;
    out_data = d;
    if (push) begin
      e.ts = tsm;
      e.aktv = a;
      e.data = ed;
      expq.push_back(e);
    end
    step();
  endtask

  task automatic drain(input int maxc);
    int n;
    n = 0;
    rec_ready = 1'b1;
    out_aktv = '0;
    while (expq.size() != 0 && n < maxc) begin
      step();
      n++;
    end
    check("drain_done", 256'(expq.size()), 256'(0));
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_valid"}, 256'(rec_valid), 256'(0));
    check({tag, "_level"}, 256'(level), 256'(0));
    check({tag, "_overflow"}, 256'(overflow), 256'(0));
    check({tag, "_drop_cnt"}, 256'(drop_cnt), 256'(0));
    check({tag, "_rec_ts"}, 256'(rec_ts), 256'(0));
    check({tag, "_rec_aktv"}, 256'(rec_aktv), 256'(0));
    check({tag, "_rec_data"}, rec_data, 256'(0));
  endtask

  initial begin
    rst = 1'b1;
    en = 1'b1;
    rec_ready = 1'b0;
    out_aktv = '0;
    out_data = '0;
    tsm = '0;
    step();
    step();
    check_zero("reset");
    rst = 1'b0;

    // Single event at timestamp 10
    for (int i = 0; i < 10; i++) step();
    rec_ready = 1'b1;
    ev(4'b0101, lanes(64'd7, 64'd99, -64'sd3, 64'd5), lanes(64'd7, 64'd0, -64'sd3, 64'd0), 1'b1);
    out_aktv = '0;
    step();
    step();
    check("single_level", 256'(level), 256'(0));

    // Back-to-back with the consumer stalled
    rec_ready = 1'b0;
    for (int k = 1; k <= 3; k++)
      ev(4'b0001, lanes(64'(k), 64'd55, 64'd66, 64'd77), lanes(64'(k), 64'd0, 64'd0, 64'd0), 1'b1);
    out_aktv = '0;
    step();
    check("b2b_level", 256'(level), 256'(3));
    drain(10);
    check("b2b_level_after", 256'(level), 256'(0));

    // Overflow: 18 events into a 16-deep buffer, last two dropped
    rec_ready = 1'b0;
    for (int k = 0; k < 18; k++)
      ev(4'b0001, lanes(64'(100 + k), 64'd1, 64'd2, 64'd3), lanes(64'(100 + k), 64'd0, 64'd0, 64'd0), k < 16);
    out_aktv = '0;
    check("ovf_level", 256'(level), 256'(16));
    check("ovf_flag", 256'(overflow), 256'(1));
    check("ovf_drop_cnt", 256'(drop_cnt), 256'(2));

    // Full buffer with a simultaneous pop accepts the push
    rec_ready = 1'b1;
    ev(4'b1000, lanes(64'd0, 64'd0, 64'd0, 64'd500), lanes(64'd0, 64'd0, 64'd0, 64'd500), 1'b1);
    rec_ready = 1'b0;
    out_aktv = '0;
    check("fullpop_level", 256'(level), 256'(16));
    check("fullpop_drop_cnt", 256'(drop_cnt), 256'(2));
    drain(40);
    check("fullpop_level_after", 256'(level), 256'(0));

    // en gating: no capture, timestamp frozen
    ts_saved = tsm;
    rec_ready = 1'b1;
    en = 1'b0;
    out_aktv = 4'hF;
    out_data = lanes(64'd1, 64'd2, 64'd3, 64'd4);
    for (int i = 0; i < 5; i++) step();
    check("gate_level", 256'(level), 256'(0));
    check("gate_valid", 256'(rec_valid), 256'(0));
    check("gate_ts_model", 256'(tsm), 256'(ts_saved));
    en = 1'b1;
    ev(4'hF, lanes(64'd9, 64'd8, 64'd7, 64'd6), lanes(64'd9, 64'd8, 64'd7, 64'd6), 1'b1);
    out_aktv = '0;
    step();
    step();
    check("gate_level_after", 256'(level), 256'(0));

    // Reset with five records buffered and the sticky flag set
    rec_ready = 1'b0;
    for (int k = 0; k < 5; k++)
      ev(4'b0010, lanes(64'd0, 64'(200 + k), 64'd0, 64'd0), lanes(64'd0, 64'(200 + k), 64'd0, 64'd0), 1'b1);
    out_aktv = '0;
    check("pre_rst_level", 256'(level), 256'(5));
    check("pre_rst_overflow", 256'(overflow), 256'(1));
    rst = 1'b1;
    rec_ready = 1'b1;
    expq.delete();
    step();
    rst = 1'b0;
    check_zero("midrst");
    ev(4'b0010, lanes(64'd0, 64'd42, 64'd0, 64'd0), lanes(64'd0, 64'd42, 64'd0, 64'd0), 1'b1);
    drain(10);
    check("post_rst_level", 256'(level), 256'(0));

    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
